// File: rtl/fir_spi_pkg.sv
// Shared constants and types for the FIR SPI receive front end.
// Optional build macro: SPI_PARITY_EN (adds a trailing even-parity bit to each frame).
package fir_spi_pkg;

  localparam logic [7:0] CMD_SAMPLE = 8'h01;
  localparam logic [7:0] CMD_COEFF  = 8'h02;

`ifdef SPI_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Command byte plus 16-bit payload, plus the parity bit when enabled
  localparam int unsigned FRAME_BITS = 8 + 16 + PARITY_BITS;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK,
    WAIT_NSS
  } rx_state_t;

endpackage

// File: rtl/fir_spi_rx_sync_edge.sv
// N-stage synchronizer for one asynchronous input, with rise/fall pulses
// taken from one extra flop behind the last synchronizer stage.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw input through the synchronizer chain and keep one delayed copy
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d);
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/fir_spi_rx.sv
// SPI-slave receiver feeding the FIR controller: collects command+payload
// frames, presents the payload on a held bus and raises dr (sample) or
// lc (coefficient) until the controller acknowledges with modwait.
// Optional build macro: SPI_PARITY_EN (25-bit frames with even parity check).
module fir_spi_rx
  import fir_spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CMD_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              sck,
  input  logic              mosi,
  input  logic              nss,
  input  logic              modwait,
  output logic [DATA_W-1:0] data,
  output logic              dr,
  output logic              lc,
  output logic              nss_fall,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned NBITS = CMD_W + DATA_W + PARITY_BITS;
  localparam int unsigned CNT_W = $clog2(NBITS + 1);

  rx_state_t          state;
  logic [NBITS-1:0]   shift_q;
  logic [CNT_W-1:0]   bit_cnt;

  logic sck_q, sck_rise, sck_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic nss_q, nss_rise, nss_fall_s;
  logic unused_sync_outs;

  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] payload;
  logic              parity_bad;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .n_rst(n_rst), .d(sck),
    .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .n_rst(n_rst), .d(mosi),
    .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nss (
    .clk(clk), .n_rst(n_rst), .d(nss),
    .q(nss_q), .rise(nss_rise), .fall(nss_fall_s)
  );

  assign unused_sync_outs = sck_q ^ sck_fall ^ mosi_rise ^ mosi_fall;

  assign cmd     = shift_q[NBITS-1 -: CMD_W];
  assign payload = shift_q[PARITY_BITS +: DATA_W];

`ifdef SPI_PARITY_EN
  assign parity_bad = ^shift_q;
`else
  assign parity_bad = 1'b0;
`endif

  // Frame FSM, handshake flags and all registered outputs
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_cnt   <= '0;
      data      <= '0;
      dr        <= 1'b0;
      lc        <= 1'b0;
      nss_fall  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      nss_fall  <= 1'b0;
      frame_err <= 1'b0;

      // Acknowledge first; a flag set in CHECK below takes precedence
      if (modwait) begin
        dr <= 1'b0;
        lc <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (nss_fall_s) begin
            nss_fall <= 1'b1;
            overrun  <= 1'b0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            state    <= RECV;
          end
        end

        RECV: begin
          if (nss_rise) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (sck_rise) begin
            shift_q <= {shift_q[NBITS-2:0], mosi_q};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(NBITS - 1)) begin
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          // Busy test uses the flags as they stood at the start of this cycle
          if (dr || lc) begin
            overrun <= 1'b1;
          end else if (parity_bad) begin
            frame_err <= 1'b1;
          end else if (cmd == CMD_W'(CMD_SAMPLE)) begin
            dr   <= 1'b1;
            data <= payload;
          end else if (cmd == CMD_W'(CMD_COEFF)) begin
            lc   <= 1'b1;
            data <= payload;
          end else begin
            frame_err <= 1'b1;
          end
          state <= WAIT_NSS;
        end

        WAIT_NSS: begin
          if (nss_q) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
